// File: rtl/mac_accum_round.sv
// mac_accum_round: frame accumulator for the multiplier column tail.
// Sums ACC_LEN signed products per frame. At frame close the sum is rounded
// half-up, arithmetically shifted right by SHIFT and saturated to OUT_W bits.
// The result is held in a one-entry output register behind a valid/ready handshake.
module mac_accum_round #(
  parameter int IN_W    = 36,
  parameter int ACC_W   = 48,
  parameter int OUT_W   = 18,
  parameter int ACC_LEN = 16,
  parameter int SHIFT   = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  input  logic             out_ready
);

  // A one-bit counter is kept for ACC_LEN == 1 so the vector stays legal;
  // it then permanently reads zero, which is also the last position.
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  // Rounding constant and output limits, expressed in the ACC_W+1 bit domain
  // used for the round/shift so that adding HALF can never wrap.
  localparam logic signed [ACC_W:0] HALF    = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

  // Round half-up toward +inf, then arithmetic shift right.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W:0] w;
    w = {s[ACC_W-1], s};
    w = w + HALF;
    return w >>> SHIFT;
  endfunction

  // Clamp to the signed OUT_W range; the MSB of the result is the saturation flag.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] r);
    logic [OUT_W:0] res;
    if (r > OUT_MAX) begin
      res = {1'b1, OUT_MAX[OUT_W-1:0]};
    end else if (r < OUT_MIN) begin
      res = {1'b1, OUT_MIN[OUT_W-1:0]};
    end else begin
      res = {1'b0, r[OUT_W-1:0]};
    end
    return res;
  endfunction

  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc_p0;
  logic signed [ACC_W-1:0]  prod_ext_p0;
  logic signed [ACC_W-1:0]  acc_base_p0;
  logic signed [ACC_W-1:0]  sum_p0;
  logic [OUT_W:0]           res_p0;
  logic                     last_p0;
  logic                     accept_p0;
  logic                     close_p0;
  logic                     vld_p1;
  logic signed [OUT_W-1:0]  data_p1;
  logic                     sat_p1;

  // ---- stage p0: accept, accumulate, round and saturate (combinational) ----
  assign last_p0     = (cnt == CNT_LAST);
  assign in_ready    = ~(last_p0 & vld_p1 & ~out_ready);
  assign accept_p0   = in_valid & in_ready;
  assign close_p0    = accept_p0 & last_p0;
  assign prod_ext_p0 = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
  // The first product of a frame starts from zero, so the accumulator never
  // needs clearing at frame close.
  assign acc_base_p0 = (cnt == '0) ? '0 : acc_p0;
  assign sum_p0      = acc_base_p0 + prod_ext_p0;
  assign res_p0      = saturate(round_shift(sum_p0));

  // Frame position counter and running partial sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc_p0 <= '0;
    end else if (accept_p0) begin
      if (last_p0) begin
        cnt <= '0;
      end else begin
        cnt    <= cnt + CNT_W'(1);
        acc_p0 <= sum_p0;
      end
    end
  end

  // ---- stage p1: one-entry output holding register ----
  // A closing accept refills the register even while it drains, giving a
  // bubble-free handoff; otherwise a consumed result just clears valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sat_p1  <= 1'b0;
    end else if (close_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= res_p0[OUT_W-1:0];
      sat_p1  <= res_p0[OUT_W];
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sat   = sat_p1;

endmodule

// File: tb/tb_mac_accum_round.sv
// Directed testbench for mac_accum_round with default parameters.
module tb_mac_accum_round;

  localparam int LEN = 16;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [35:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [17:0] out_data;
  logic        out_sat;
  logic        out_ready;

  int n_checks;
  int n_fail;

  mac_accum_round dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input longint v);
    in_valid = 1'b1;
    in_data  = v[35:0];
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic push_frame(input longint v0, input longint vr);
    push(v0);
    for (int i = 1; i < LEN; i++) push(vr);
  endtask

  task automatic idle_drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 18'd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_state: valid=%b data=%0d sat=%b in_ready=%b required 0 0 0 1",
               out_valid, out_data, out_sat, in_ready);
      n_fail++;
    end
  endtask

  task automatic test_basic();
    idle_drain();
    for (int i = 0; i < LEN; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        $display("FAIL basic_in_ready[%0d]: got %b required 1", i, in_ready);
        n_fail++;
      end
      if (i == LEN - 1) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          $display("FAIL basic_early_valid: got %b required 0", out_valid);
          n_fail++;
        end
      end
      push(64'sd1 <<< 17);
    end
    n_checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 18'sd16 || out_sat !== 1'b0) begin
      $display("FAIL basic_result: valid=%b data=%0d sat=%b required 1 16 0",
               out_valid, $signed(out_data), out_sat);
      n_fail++;
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || $signed(out_data) !== 18'sd16) begin
      $display("FAIL basic_drain: valid=%b data=%0d required 0 16", out_valid, $signed(out_data));
      n_fail++;
    end
  endtask

  task automatic check_frame(input string name, input longint v0, input longint vr,
                             input logic signed [17:0] e, input logic es);
    idle_drain();
    push_frame(v0, vr);
    n_checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== e || out_sat !== es) begin
      $display("FAIL %s: valid=%b data=%0d sat=%b required 1 %0d %b",
               name, out_valid, $signed(out_data), out_sat, e, es);
      n_fail++;
    end
  endtask

  task automatic test_rounding();
    check_frame("round_pos_half", 64'sd65536, 64'sd0, 18'sd1, 1'b0);
    check_frame("round_neg_half", -64'sd65536, 64'sd0, 18'sd0, 1'b0);
    check_frame("round_neg_past_half", -64'sd65537, 64'sd0, -18'sd1, 1'b0);
    check_frame("round_just_below_half", 64'sd65535, 64'sd0, 18'sd0, 1'b0);
  endtask

  task automatic test_saturation();
    check_frame("sat_pos", 64'sd1 <<< 34, 64'sd1 <<< 34, 18'sd131071, 1'b1);
    check_frame("sat_neg", -(64'sd1 <<< 34), -(64'sd1 <<< 34), -18'sd131072, 1'b1);
    check_frame("max_exact", 64'sd131071 <<< 17, 64'sd0, 18'sd131071, 1'b0);
    check_frame("max_rounds_over", (64'sd131071 <<< 17) + 64'sd65536, 64'sd0, 18'sd131071, 1'b1);
    check_frame("min_exact", -(64'sd131072 <<< 17), 64'sd0, -18'sd131072, 1'b0);
    check_frame("min_under", -(64'sd131072 <<< 17) - 64'sd65537, 64'sd0, -18'sd131072, 1'b1);
  endtask

  task automatic test_backpressure();
    idle_drain();
    out_ready = 1'b0;
    push_frame(64'sd1 <<< 17, 64'sd1 <<< 17);
    for (int i = 1; i < LEN; i++) push(64'sd1 <<< 18);
    n_checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 18'sd16) begin
      $display("FAIL bp_held: valid=%b data=%0d required 1 16", out_valid, $signed(out_data));
      n_fail++;
    end
    in_valid = 1'b1;
    in_data  = 36'h1 << 18;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || $signed(out_data) !== 18'sd16) begin
        $display("FAIL bp_stall[%0d]: in_ready=%b valid=%b data=%0d required 0 1 16",
                 i, in_ready, out_valid, $signed(out_data));
        n_fail++;
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    n_checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 18'sd32 || in_ready !== 1'b1) begin
      $display("FAIL bp_release: valid=%b data=%0d in_ready=%b required 1 32 1",
               out_valid, $signed(out_data), in_ready);
      n_fail++;
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 18'sd32) begin
      $display("FAIL bp_hold2: valid=%b data=%0d required 1 32", out_valid, $signed(out_data));
      n_fail++;
    end
  endtask

  task automatic test_drain_and_close();
    idle_drain();
    out_ready = 1'b0;
    push_frame(64'sd1 <<< 17, 64'sd1 <<< 17);
    for (int i = 1; i < LEN; i++) push(64'sd3 <<< 17);
    out_ready = 1'b1;
    push(64'sd3 <<< 17);
    n_checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 18'sd48 || out_sat !== 1'b0) begin
      $display("FAIL drain_close: valid=%b data=%0d sat=%b required 1 48 0",
               out_valid, $signed(out_data), out_sat);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    idle_drain();
    for (int i = 0; i < 2 * LEN; i++) begin
      push((i < LEN) ? (64'sd5 <<< 17) : -(64'sd1 <<< 17));
      n_checks++;
      if (out_valid !== ((i % LEN) == LEN - 1)) begin
        $display("FAIL b2b_valid[%0d]: got %b required %b", i, out_valid, ((i % LEN) == LEN - 1));
        n_fail++;
      end
      if (i == LEN - 1 || i == 2 * LEN - 1) begin
        n_checks++;
        if ($signed(out_data) !== ((i < LEN) ? 18'sd80 : -18'sd16)) begin
          $display("FAIL b2b_data[%0d]: got %0d required %0d", i, $signed(out_data),
                   ((i < LEN) ? 80 : -16));
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_gaps();
    idle_drain();
    for (int i = 0; i < LEN; i++) begin
      push(64'sd1 <<< 17);
      if (i != LEN - 1) begin
        in_valid = 1'b0;
        in_data  = 36'h1 << 34;
        step();
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 18'sd16) begin
      $display("FAIL gaps_result: valid=%b data=%0d required 1 16", out_valid, $signed(out_data));
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_frame();
    idle_drain();
    out_ready = 1'b0;
    push_frame(64'sd1 <<< 17, 64'sd1 <<< 17);
    for (int i = 0; i < 7; i++) push(64'sd1 <<< 20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 18'd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL midreset_state: valid=%b data=%0d sat=%b in_ready=%b required 0 0 0 1",
               out_valid, $signed(out_data), out_sat, in_ready);
      n_fail++;
    end
    out_ready = 1'b1;
    push_frame(64'sd1 <<< 17, 64'sd1 <<< 17);
    n_checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 18'sd16 || out_sat !== 1'b0) begin
      $display("FAIL midreset_result: valid=%b data=%0d sat=%b required 1 16 0",
               out_valid, $signed(out_data), out_sat);
      n_fail++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_drain_and_close();
    test_back_to_back();
    test_gaps();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
